boundary_scan_register: RTL

Parametrised boundary-scan data register: WIDTH scan cells share one clock and present one serial path (tdi → tdo) plus WIDTH parallel pins. Each cell has a capture/shift stage and an update (hold) stage. A test/normal mux per pin drives either the functional value or the updated test value. The block sits between the TAP controller (which supplies capture_dr/shift_dr/update_dr/mode) and the device pins. It generalises the single-cell design to a full chain with a shift-position counter, a wrap flag and a programmable reset value for the update stage.

---
 rtl/boundary_scan_register.sv | 65 ++++++
 1 files changed

// File: rtl/boundary_scan_register.sv
// Boundary-scan data register chain: WIDTH capture/shift cells with update stage and test/normal pin mux.
// Latency: capture/shift/update take effect on the next clk edge; tdo and par_out are combinational from state.
// Backpressure: none; TAP commands are accepted every cycle, capture_dr wins over shift_dr.
module boundary_scan_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] UPD_RESET = {WIDTH{1'b0}},
    parameter int               CW        = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    input  logic             tdi,
    output logic             tdo,
    input  logic             capture_dr,
    input  logic             shift_dr,
    input  logic             update_dr,
    input  logic             mode,
    output logic [CW-1:0]    shift_cnt,
    output logic             cnt_wrap
);

    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] upd_q, upd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        cap_d  = cap_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        // update samples the pre-edge capture word, regardless of capture/shift this cycle
        upd_d  = update_dr ? cap_q : upd_q;
        if (capture_dr) begin
            cap_d = par_in;
            cnt_d = '0;
        end else if (shift_dr) begin
            cap_d  = {tdi, cap_q[WIDTH-1:1]};
            wrap_d = (cnt_q == CNT_MAX);
            cnt_d  = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q  <= '0;
            upd_q  <= UPD_RESET;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            upd_q  <= upd_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
        end
    end

    assign tdo       = cap_q[0];
    assign par_out   = mode ? upd_q : par_in;
    assign shift_cnt = cnt_q;
    assign cnt_wrap  = wrap_q;

endmodule
